ahb_sbus_arbiter: RTL and testbench

Two-master AHB5-Lite arbiter that shares one downstream AHB port between the Hazard3 core's AHB master and the debug system-bus (sbus) valid/ready requester. It sits between hazard3_cpu_1port and the SoC interconnect. The core has priority by default; a starvation counter bounds debug latency. Sbus requests are converted into single NONSEQ transfers, and illegal sbus requests are rejected locally.

---
 rtl/ahb_sbus_arbiter.sv | 83 ++++++++
 tb/tb_ahb_sbus_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ahb_sbus_arbiter.sv
// ahb_sbus_arbiter: shares one AHB5-Lite port between the core and the debug sbus requester
module ahb_sbus_arbiter #(
  parameter int W_ADDR        = 32,
  parameter int W_DATA        = 32,
  parameter int SBUS_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_ADDR-1:0] cpu_haddr,
  input  logic              cpu_hwrite,
  input  logic [1:0]        cpu_htrans,
  input  logic [2:0]        cpu_hsize,
  input  logic [3:0]        cpu_hprot,
  input  logic [W_DATA-1:0] cpu_hwdata,
  output logic              cpu_hready,
  output logic              cpu_hresp,
  output logic [W_DATA-1:0] cpu_hrdata,
  input  logic [W_ADDR-1:0] sbus_addr,
  input  logic              sbus_write,
  input  logic [1:0]        sbus_size,
  input  logic [W_DATA-1:0] sbus_wdata,
  input  logic              sbus_vld,
  output logic              sbus_rdy,
  output logic              sbus_err,
  output logic [W_DATA-1:0] sbus_rdata,
  output logic [W_ADDR-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [3:0]        hprot,
  output logic [7:0]        hmaster,
  output logic [W_DATA-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [W_DATA-1:0] hrdata
);
  typedef enum logic [1:0] {NONE, CPU, SBUS, REJ} owner_t;
  owner_t owner_q, owner_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic sbus_done_q, sbus_done_d;
  logic [W_DATA-1:0] sbus_wdata_q, sbus_wdata_d;
  logic cpu_req, sbus_req, sbus_bad, sel_sbus;
  // Address-phase arbitration, outputs and next state; a grant only takes effect when hready is high
  always_comb begin
    cpu_req      = cpu_htrans[1];
    sbus_req     = sbus_vld && !sbus_done_q;
    sbus_bad     = (sbus_size == 2'd3) || (sbus_size == 2'd1 && sbus_addr[0]) || (sbus_size == 2'd2 && |sbus_addr[1:0]);
    sel_sbus     = sbus_req && (!cpu_req || wait_cnt_q >= 8'(SBUS_MAX_WAIT));
    htrans       = rst ? 2'b00 : sel_sbus ? (sbus_bad ? 2'b00 : 2'b10) : cpu_htrans;
    haddr        = sel_sbus ? sbus_addr : cpu_haddr;
    hwrite       = sel_sbus ? sbus_write : cpu_hwrite;
    hsize        = sel_sbus ? {1'b0, sbus_size} : cpu_hsize;
    hprot        = sel_sbus ? 4'b0011 : cpu_hprot;
    hmaster      = (!rst && sel_sbus && !sbus_bad) ? 8'h01 : 8'h00;
    hwdata       = owner_q == SBUS ? sbus_wdata_q : cpu_hwdata;
    sbus_rdy     = !rst && (owner_q == REJ || (owner_q == SBUS && hready));
    sbus_err     = sbus_rdy && (owner_q == REJ || hresp);
    sbus_rdata   = hrdata;
    cpu_hready   = rst || (!(cpu_req && (sel_sbus || !hready)) && (owner_q != CPU || hready));
    cpu_hresp    = !rst && owner_q == CPU && hresp;
    cpu_hrdata   = hrdata;
    owner_d      = hready ? (sel_sbus ? (sbus_bad ? REJ : SBUS) : cpu_req ? CPU : NONE)
                          : (owner_q == REJ ? NONE : owner_q);
    wait_cnt_d   = !hready ? wait_cnt_q : sel_sbus ? 8'd0
                 : (cpu_req && sbus_req) ? 8'(wait_cnt_q + 8'd1) : wait_cnt_q;
    sbus_done_d  = sbus_rdy ? 1'b0 : (hready && sel_sbus) ? 1'b1 : sbus_done_q;
    sbus_wdata_d = (hready && sel_sbus) ? sbus_wdata : sbus_wdata_q;
  end
  // State registers; reset abandons any data phase without reporting completion
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= NONE;
      wait_cnt_q   <= 8'd0;
      sbus_done_q  <= 1'b0;
      sbus_wdata_q <= '0;
    end else begin
      owner_q      <= owner_d;
      wait_cnt_q   <= wait_cnt_d;
      sbus_done_q  <= sbus_done_d;
      sbus_wdata_q <= sbus_wdata_d;
    end
  end
endmodule

// File: tb/tb_ahb_sbus_arbiter.sv
// tb_ahb_sbus_arbiter: vector table with a scoreboard queue checked on the falling edge
module tb_ahb_sbus_arbiter;
  localparam logic [31:0] CA = 32'h0000_1000;
  localparam logic [31:0] CW = 32'hC0C0_C0C0;
  localparam logic [31:0] SW = 32'h5A5A_5A5A;
  logic clk = 0, rst = 1;
  logic [31:0] cpu_haddr = CA, cpu_hwdata = CW, cpu_hrdata;
  logic cpu_hwrite = 0, cpu_hready, cpu_hresp;
  logic [1:0] cpu_htrans = 0;
  logic [2:0] cpu_hsize = 3'd2;
  logic [3:0] cpu_hprot = 4'b1010;
  logic [31:0] sbus_addr = 0, sbus_wdata = SW, sbus_rdata;
  logic sbus_write = 0, sbus_vld = 0, sbus_rdy, sbus_err;
  logic [1:0] sbus_size = 2'd2;
  logic [31:0] haddr, hwdata, hrdata = 0;
  logic hwrite, hready = 1, hresp = 0;
  logic [1:0] htrans;
  logic [2:0] hsize;
  logic [3:0] hprot;
  logic [7:0] hmaster;
  int checks = 0, errors = 0, row = 0;

  always #5 clk = ~clk;

  ahb_sbus_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_haddr(cpu_haddr), .cpu_hwrite(cpu_hwrite), .cpu_htrans(cpu_htrans), .cpu_hsize(cpu_hsize),
    .cpu_hprot(cpu_hprot), .cpu_hwdata(cpu_hwdata), .cpu_hready(cpu_hready), .cpu_hresp(cpu_hresp),
    .cpu_hrdata(cpu_hrdata),
    .sbus_addr(sbus_addr), .sbus_write(sbus_write), .sbus_size(sbus_size), .sbus_wdata(sbus_wdata),
    .sbus_vld(sbus_vld), .sbus_rdy(sbus_rdy), .sbus_err(sbus_err), .sbus_rdata(sbus_rdata),
    .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hprot(hprot), .hmaster(hmaster),
    .hwdata(hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  typedef struct {
    logic rst; logic [1:0] ct; logic sv; logic [31:0] sa; logic [1:0] ss; logic sw;
    logic hr; logic hp; logic [31:0] hd;
    logic [1:0] e_tr; logic [7:0] e_ma; logic [31:0] e_ad; logic [2:0] e_sz;
    logic e_chr; logic e_chp; logic e_rdy; logic e_err; logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic r, logic [1:0] ct, logic sv, logic [31:0] sa, logic [1:0] ss, logic sw,
                              logic hr, logic hp, logic [31:0] hd, logic [1:0] e_tr, logic [7:0] e_ma,
                              logic [31:0] e_ad, logic [2:0] e_sz, logic e_chr, logic e_chp, logic e_rdy,
                              logic e_err, logic [31:0] e_wd);
    vec_t v;
    v.rst = r; v.ct = ct; v.sv = sv; v.sa = sa; v.ss = ss; v.sw = sw; v.hr = hr; v.hp = hp; v.hd = hd;
    v.e_tr = e_tr; v.e_ma = e_ma; v.e_ad = e_ad; v.e_sz = e_sz; v.e_chr = e_chr; v.e_chp = e_chp;
    v.e_rdy = e_rdy; v.e_err = e_err; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; cpu_htrans = v.ct; sbus_vld = v.sv; sbus_addr = v.sa; sbus_size = v.ss;
    sbus_write = v.sw; hready = v.hr; hresp = v.hp; hrdata = v.hd;
    sb.push_back(v);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk("htrans", 32'(htrans), 32'(e.e_tr));
      chk("cpu_hready", 32'(cpu_hready), 32'(e.e_chr));
      chk("cpu_hresp", 32'(cpu_hresp), 32'(e.e_chp));
      chk("sbus_rdy", 32'(sbus_rdy), 32'(e.e_rdy));
      chk("cpu_hrdata", cpu_hrdata, e.hd);
      if (e.e_tr != 2'b00 || e.rst) chk("hmaster", 32'(hmaster), 32'(e.e_ma));
      if (e.e_tr != 2'b00) begin
        chk("haddr", haddr, e.e_ad);
        chk("hsize", 32'(hsize), 32'(e.e_sz));
        chk("hwrite", 32'(hwrite), 32'(e.e_ma[0] ? e.sw : 1'b0));
        chk("hprot", 32'(hprot), 32'(e.e_ma[0] ? 4'b0011 : 4'b1010));
      end
      if (!e.rst) chk("hwdata", hwdata, e.e_wd);
      if (e.e_rdy) begin
        chk("sbus_err", 32'(sbus_err), 32'(e.e_err));
        if (!e.e_err) chk("sbus_rdata", sbus_rdata, e.hd);
      end
      row++;
    end
  end

  initial begin
    // reset, with requests present that must be masked
    tbl.push_back(mk(1, 2, 1, 32'h40, 2, 0, 1, 0, 0, 0, 0, CA, 2, 1, 0, 0, 0, CW));
    tbl.push_back(mk(1, 0, 0, 32'h0, 2, 0, 1, 0, 0, 0, 0, CA, 2, 1, 0, 0, 0, CW));
    // sbus word read, core idle
    tbl.push_back(mk(0, 0, 1, 32'h40, 2, 0, 1, 0, 0, 2, 1, 32'h40, 2, 1, 0, 0, 0, CW));
    tbl.push_back(mk(0, 0, 1, 32'h40, 2, 0, 1, 0, 32'hDEADBEEF, 0, 0, CA, 2, 1, 0, 1, 0, SW));
    tbl.push_back(mk(0, 0, 0, 32'h0, 2, 0, 1, 0, 0, 0, 0, CA, 2, 1, 0, 0, 0, CW));
    // starvation: 8 core grants, then one sbus grant with the core stalled
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 2, 1, 32'h44, 2, 1, 1, 0, 0, 2, 0, CA, 2, 1, 0, 0, 0, CW));
    tbl.push_back(mk(0, 2, 1, 32'h44, 2, 1, 1, 0, 0, 2, 1, 32'h44, 2, 0, 0, 0, 0, CW));
    tbl.push_back(mk(0, 2, 1, 32'h44, 2, 1, 1, 0, 0, 2, 0, CA, 2, 1, 0, 1, 0, SW));
    tbl.push_back(mk(0, 0, 0, 32'h0, 2, 0, 1, 0, 0, 0, 0, CA, 2, 1, 0, 0, 0, CW));
    // rejections: misaligned half, then size 3
    tbl.push_back(mk(0, 0, 1, 32'h41, 1, 1, 1, 0, 0, 0, 0, CA, 2, 1, 0, 0, 0, CW));
    tbl.push_back(mk(0, 0, 1, 32'h41, 1, 1, 1, 0, 0, 0, 0, CA, 2, 1, 0, 1, 1, CW));
    tbl.push_back(mk(0, 0, 1, 32'h40, 3, 1, 1, 0, 0, 0, 0, CA, 2, 1, 0, 0, 0, CW));
    tbl.push_back(mk(0, 0, 1, 32'h40, 3, 1, 1, 0, 0, 0, 0, CA, 2, 1, 0, 1, 1, CW));
    tbl.push_back(mk(0, 0, 0, 32'h0, 2, 0, 1, 0, 0, 0, 0, CA, 2, 1, 0, 0, 0, CW));
    // sbus write: 2 wait states then two-cycle ERROR, core address pending and held
    tbl.push_back(mk(0, 0, 1, 32'h80, 2, 1, 1, 0, 0, 2, 1, 32'h80, 2, 1, 0, 0, 0, CW));
    tbl.push_back(mk(0, 2, 1, 32'h80, 2, 1, 0, 0, 0, 2, 0, CA, 2, 0, 0, 0, 0, SW));
    tbl.push_back(mk(0, 2, 1, 32'h80, 2, 1, 0, 0, 0, 2, 0, CA, 2, 0, 0, 0, 0, SW));
    tbl.push_back(mk(0, 2, 1, 32'h80, 2, 1, 0, 1, 0, 2, 0, CA, 2, 0, 0, 0, 0, SW));
    tbl.push_back(mk(0, 2, 1, 32'h80, 2, 1, 1, 1, 0, 2, 0, CA, 2, 1, 0, 1, 1, SW));
    tbl.push_back(mk(0, 0, 0, 32'h0, 2, 0, 1, 0, 32'h11111111, 0, 0, CA, 2, 1, 0, 0, 0, CW));
    // core read completes in the same cycle as an sbus byte grant
    tbl.push_back(mk(0, 2, 0, 32'h0, 2, 0, 1, 0, 0, 2, 0, CA, 2, 1, 0, 0, 0, CW));
    tbl.push_back(mk(0, 0, 1, 32'h100, 0, 0, 1, 0, 32'hCAFEF00D, 2, 1, 32'h100, 0, 1, 0, 0, 0, CW));
    tbl.push_back(mk(0, 0, 1, 32'h100, 0, 0, 1, 0, 32'hAB, 0, 0, CA, 2, 1, 0, 1, 0, SW));
    // core error response passes through
    tbl.push_back(mk(0, 2, 0, 32'h0, 2, 0, 1, 0, 0, 2, 0, CA, 2, 1, 0, 0, 0, CW));
    tbl.push_back(mk(0, 0, 0, 32'h0, 2, 0, 0, 1, 0, 0, 0, CA, 2, 0, 1, 0, 0, CW));
    tbl.push_back(mk(0, 0, 0, 32'h0, 2, 0, 1, 1, 0, 0, 0, CA, 2, 1, 1, 0, 0, CW));
    tbl.push_back(mk(0, 0, 0, 32'h0, 2, 0, 1, 0, 0, 0, 0, CA, 2, 1, 0, 0, 0, CW));
    // reset during a stalled sbus data phase, then a fresh request
    tbl.push_back(mk(0, 0, 1, 32'h200, 2, 0, 1, 0, 0, 2, 1, 32'h200, 2, 1, 0, 0, 0, CW));
    tbl.push_back(mk(0, 0, 1, 32'h200, 2, 0, 0, 0, 0, 0, 0, CA, 2, 1, 0, 0, 0, SW));
    tbl.push_back(mk(1, 0, 0, 32'h0, 2, 0, 0, 0, 0, 0, 0, CA, 2, 1, 0, 0, 0, CW));
    tbl.push_back(mk(0, 0, 0, 32'h0, 2, 0, 1, 0, 0, 0, 0, CA, 2, 1, 0, 0, 0, CW));
    tbl.push_back(mk(0, 0, 1, 32'h204, 2, 0, 1, 0, 0, 2, 1, 32'h204, 2, 1, 0, 0, 0, CW));
    tbl.push_back(mk(0, 0, 1, 32'h204, 2, 0, 1, 0, 32'h12345678, 0, 0, CA, 2, 1, 0, 1, 0, SW));
    tbl.push_back(mk(0, 0, 0, 32'h0, 2, 0, 1, 0, 0, 0, 0, CA, 2, 1, 0, 0, 0, CW));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
